alk_carry_seq: RTL and testbench
================================

// Module: alk_carry_seq
//
// PURPOSE
//  ALK carry sequencer: owns the ALKC microarchitectural carry flag and the carry_invert_h
//  control that feed the ALK carry-out multiplexer. Runs the multi-cycle non-restoring
//  divide-step sequence (add/subtract selection per step, quotient bit into ALKC,
//  final remainder fix-up) and plain ALKC load/clear for ordinary microinstructions.
//  Sits in DC615 ALK between the ROT/ALPCTL decoders and the carry-out mux.
//
// PARAMETERS
//  STEP_COUNT  32  divide iterations per DIV sequence (>=1)
//  CNT_W       6   width of step counter; must hold STEP_COUNT-1
//
// PORTS
//  clk_h           in   1      microcycle clock; all state updates on rising edge
//  reset_h         in   1      synchronous reset, active-high
//  ucyc_en_h       in   1      microcycle advance strobe; 0 = stall, all state holds
//  alkc_load_h     in   1      IDLE only: ALKC <= alu_cout_h
//  alkc_clr_h      in   1      IDLE only: ALKC <= 0 (priority over load)
//  div_start_h     in   1      begin divide sequence (accepted in IDLE only)
//  abort_h         in   1      terminate sequence (microtrap)
//  alu_cout_h      in   1      ALU carry out of the current cycle
//  alu_sign_h      in   1      ALU result sign bit of the current cycle
//  alkc_flag_h     out  1      ALKC flag to carry-out mux
//  carry_invert_h  out  1      1 = subtract step (invert carry-in)
//  busy_h          out  1      sequence active (DIVSTEP or DIVFIX)
//  done_h          out  1      one-cycle pulse, sequence completed normally
//  step_cnt_h      out  CNT_W  remaining divide steps
//
// BEHAVIOUR
//  - Reset (wins over all inputs): state=IDLE, alkc_flag_h=0, carry_invert_h=0,
//    busy_h=0, done_h=0, step_cnt_h=0.
//  - Nothing changes when ucyc_en_h=0, except reset; done_h holds its value during stall.
//  - Priority on enabled edge: reset > abort_h > state action.
//  - States: IDLE, DIVSTEP, DIVFIX, DONE. busy_h=1 in DIVSTEP/DIVFIX (registered from state).
//  - IDLE: alkc_clr_h -> ALKC=0; else alkc_load_h -> ALKC=alu_cout_h; else hold.
//    div_start_h -> DIVSTEP, step_cnt=STEP_COUNT-1, carry_invert_h=1 (first step subtracts).
//    Load/clear on the start edge still apply. carry_invert_h=0 otherwise.
//  - DIVSTEP, each enabled edge: q = ~alu_sign_h; ALKC<=q; carry_invert_h<=q
//    (non-negative partial remainder -> subtract next, negative -> add next).
//    step_cnt!=0: decrement, stay. step_cnt==0: alu_sign_h=1 -> DIVFIX, else DONE.
//    load/clear/div_start inputs ignored.
//  - DIVFIX: carry_invert_h=0 during the state (restore add); next enabled edge -> DONE; ALKC holds.
//  - DONE: done_h=1 for exactly one enabled cycle, carry_invert_h=0; -> IDLE.
//  - abort_h: any state -> IDLE next enabled edge; carry_invert_h=0, step_cnt=0, busy_h=0,
//    no done_h pulse; ALKC retains its last value. abort in IDLE: no-op beyond clearing invert.
//  - Latency: start edge to done_h = STEP_COUNT+1 enabled cycles (+1 if DIVFIX taken).
//  - Counter never wraps: decrement only when nonzero.
//
// STRUCTURE
//  - Shared package alk_pkg: state enum (ALKSEQ_IDLE/DIVSTEP/DIVFIX/DONE), default STEP_COUNT.
//  - One sub-module natural: alk_step_ctr (loadable down-counter with zero flag, enable).
//  - Outputs registered; no combinational path from inputs to outputs.
//
// TESTING
//  - Reset mid-DIVSTEP at step_cnt=17 -> next edge all outputs 0, state IDLE.
//  - IDLE: alkc_load_h=1, alu_cout_h=1 -> ALKC=1; then clr_h=1, load_h=1 -> ALKC=0.
//  - STEP_COUNT=4, start, alu_sign_h pattern 0,1,0,0 -> ALKC seq 1,0,1,1, invert 1,0,1,1,
//    final sign 0 -> DONE, done_h pulse 5 cycles after start.
//  - Same with final sign 1 -> DIVFIX (invert=0) one cycle, done_h 6 cycles after start.
//  - ucyc_en_h=0 for 3 cycles mid-sequence -> step_cnt, ALKC, invert frozen; resumes exactly.
//  - abort_h at step 2 -> IDLE, busy_h=0, no done_h, ALKC unchanged; div_start_h while busy ignored.

Source files
------------

// File: rtl/alk_pkg.sv
// Shared types and defaults for the ALK carry sequencer.
package alk_pkg;

  typedef enum logic [1:0] {
    ALKSEQ_IDLE    = 2'd0,
    ALKSEQ_DIVSTEP = 2'd1,
    ALKSEQ_DIVFIX  = 2'd2,
    ALKSEQ_DONE    = 2'd3
  } alkseq_state_e;

  localparam int unsigned ALK_STEP_COUNT = 32;
  localparam int unsigned ALK_CNT_W      = 6;

endpackage

// File: rtl/alk_carry_seq_if.sv
// Microcycle control / status bundle between the ALK decoders and the carry sequencer.
interface alk_carry_seq_if
  import alk_pkg::*;
#(
  parameter int unsigned CNT_W = ALK_CNT_W
);
  logic             ucyc_en_h;
  logic             alkc_load_h;
  logic             alkc_clr_h;
  logic             div_start_h;
  logic             abort_h;
  logic             alu_cout_h;
  logic             alu_sign_h;
  logic             alkc_flag_h;
  logic             carry_invert_h;
  logic             busy_h;
  logic             done_h;
  logic [CNT_W-1:0] step_cnt_h;

  modport master (
    output ucyc_en_h, alkc_load_h, alkc_clr_h, div_start_h, abort_h, alu_cout_h, alu_sign_h,
    input  alkc_flag_h, carry_invert_h, busy_h, done_h, step_cnt_h
  );

  modport slave (
    input  ucyc_en_h, alkc_load_h, alkc_clr_h, div_start_h, abort_h, alu_cout_h, alu_sign_h,
    output alkc_flag_h, carry_invert_h, busy_h, done_h, step_cnt_h
  );
endinterface

// File: rtl/alk_step_ctr.sv
// Loadable divide-step down-counter; saturates at zero and never wraps.
module alk_step_ctr #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_h,
  input  logic             reset_h,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_h) begin
    if (reset_h) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_clr)                    r_cnt <= '0;
      else if (i_load)              r_cnt <= i_load_val;
      else if (i_dec && !o_zero)    r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/alk_carry_seq.sv
// ALK carry sequencer: ALKC flag ownership plus the non-restoring divide-step sequence.
module alk_carry_seq
  import alk_pkg::*;
#(
  parameter int unsigned STEP_COUNT = ALK_STEP_COUNT,
  parameter int unsigned CNT_W      = ALK_CNT_W
) (
  input  logic          clk_h,
  input  logic          reset_h,
  alk_carry_seq_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(STEP_COUNT - 1);

  alkseq_state_e    r_state, w_state_nxt;
  logic             r_alkc, r_inv, r_busy, r_done;
  logic             w_alkc_nxt, w_inv_nxt, w_busy_nxt, w_done_nxt;
  logic             w_cnt_clr, w_cnt_load, w_cnt_dec, w_cnt_zero;
  logic [CNT_W-1:0] w_cnt;

  alk_step_ctr #(.CNT_W(CNT_W)) u_step_ctr (
    .clk_h      (clk_h),
    .reset_h    (reset_h),
    .i_en       (bus.ucyc_en_h),
    .i_clr      (w_cnt_clr),
    .i_load     (w_cnt_load),
    .i_dec      (w_cnt_dec),
    .i_load_val (LAST_IDX),
    .o_cnt      (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  // State and all registered outputs; a stalled microcycle freezes everything.
  always_ff @(posedge clk_h) begin
    if (reset_h) begin
      r_state <= ALKSEQ_IDLE;
      r_alkc  <= 1'b0;
      r_inv   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (bus.ucyc_en_h) begin
      r_state <= w_state_nxt;
      r_alkc  <= w_alkc_nxt;
      r_inv   <= w_inv_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.abort_h) begin
      w_state_nxt = ALKSEQ_IDLE;
    end else begin
      case (r_state)
        ALKSEQ_IDLE:    if (bus.div_start_h) w_state_nxt = ALKSEQ_DIVSTEP;
        ALKSEQ_DIVSTEP: if (w_cnt_zero)
                          w_state_nxt = bus.alu_sign_h ? ALKSEQ_DIVFIX : ALKSEQ_DONE;
        ALKSEQ_DIVFIX:  w_state_nxt = ALKSEQ_DONE;
        default:        w_state_nxt = ALKSEQ_IDLE;
      endcase
    end
  end

  // Quotient bit q = ~sign: non-negative remainder means subtract on the next step.
  always_comb begin
    w_alkc_nxt = r_alkc;
    w_inv_nxt  = 1'b0;
    w_done_nxt = 1'b0;
    w_busy_nxt = (w_state_nxt == ALKSEQ_DIVSTEP) || (w_state_nxt == ALKSEQ_DIVFIX);
    w_cnt_clr  = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    if (bus.abort_h) begin
      w_cnt_clr = 1'b1;
    end else begin
      case (r_state)
        ALKSEQ_IDLE: begin
          if (bus.alkc_clr_h)       w_alkc_nxt = 1'b0;
          else if (bus.alkc_load_h) w_alkc_nxt = bus.alu_cout_h;
          if (bus.div_start_h) begin
            w_inv_nxt  = 1'b1;
            w_cnt_load = 1'b1;
          end
        end
        ALKSEQ_DIVSTEP: begin
          w_alkc_nxt = ~bus.alu_sign_h;
          w_inv_nxt  = ~bus.alu_sign_h;
          w_cnt_dec  = 1'b1;
        end
        ALKSEQ_DONE:    w_done_nxt = 1'b1;
        default:        ;
      endcase
    end
  end

  assign bus.alkc_flag_h    = r_alkc;
  assign bus.carry_invert_h = r_inv;
  assign bus.busy_h         = r_busy;
  assign bus.done_h         = r_done;
  assign bus.step_cnt_h     = w_cnt;
endmodule

// File: tb/tb_alk_carry_seq.sv
// Directed bench for alk_carry_seq: a 32-step instance for reset, a 4-step instance for sequencing.
module tb_alk_carry_seq;
  logic clk_h = 1'b0;
  logic reset_h;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_h = ~clk_h;

  alk_carry_seq_if #(.CNT_W(6)) bus32 ();
  alk_carry_seq_if #(.CNT_W(6)) bus4 ();

  alk_carry_seq #(.STEP_COUNT(32), .CNT_W(6)) dut32 (.clk_h(clk_h), .reset_h(reset_h), .bus(bus32));
  alk_carry_seq #(.STEP_COUNT(4),  .CNT_W(6)) dut4  (.clk_h(clk_h), .reset_h(reset_h), .bus(bus4));

  // Observed vectors packed as {alkc, invert, busy, done, step_cnt[5:0]}
  logic [9:0] obs32, obs4;
  assign obs32 = {bus32.alkc_flag_h, bus32.carry_invert_h, bus32.busy_h, bus32.done_h, bus32.step_cnt_h};
  assign obs4  = {bus4.alkc_flag_h,  bus4.carry_invert_h,  bus4.busy_h,  bus4.done_h,  bus4.step_cnt_h};

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  task automatic idle_inputs();
    bus32.ucyc_en_h = 1'b1; bus32.alkc_load_h = 1'b0; bus32.alkc_clr_h = 1'b0;
    bus32.div_start_h = 1'b0; bus32.abort_h = 1'b0; bus32.alu_cout_h = 1'b0; bus32.alu_sign_h = 1'b0;
    bus4.ucyc_en_h = 1'b1; bus4.alkc_load_h = 1'b0; bus4.alkc_clr_h = 1'b0;
    bus4.div_start_h = 1'b0; bus4.abort_h = 1'b0; bus4.alu_cout_h = 1'b0; bus4.alu_sign_h = 1'b0;
  endtask

  task automatic test_reset();
    reset_h = 1'b1;
    tick(); tick();
    n_tests++;
    if (obs32 !== 10'b0) begin n_fail++; $display("FAIL reset32_init: got %b expected %b", obs32, 10'b0); end
    n_tests++;
    if (obs4 !== 10'b0) begin n_fail++; $display("FAIL reset4_init: got %b expected %b", obs4, 10'b0); end
    reset_h = 1'b0;
    bus32.div_start_h = 1'b1;
    tick();
    bus32.div_start_h = 1'b0;
    n_tests++;
    if (obs32 !== {4'b0110, 6'd31}) begin n_fail++; $display("FAIL reset32_start: got %b expected %b", obs32, {4'b0110, 6'd31}); end
    repeat (14) tick();
    n_tests++;
    if (obs32 !== {4'b1110, 6'd17}) begin n_fail++; $display("FAIL reset32_at17: got %b expected %b", obs32, {4'b1110, 6'd17}); end
    // Reset must win even with the microcycle stalled
    reset_h = 1'b1;
    bus32.ucyc_en_h = 1'b0;
    tick();
    reset_h = 1'b0;
    bus32.ucyc_en_h = 1'b1;
    n_tests++;
    if (obs32 !== 10'b0) begin n_fail++; $display("FAIL reset32_mid: got %b expected %b", obs32, 10'b0); end
    // Back in IDLE: a fresh start is accepted
    bus32.div_start_h = 1'b1;
    tick();
    bus32.div_start_h = 1'b0;
    n_tests++;
    if (obs32 !== {4'b0110, 6'd31}) begin n_fail++; $display("FAIL reset32_restart: got %b expected %b", obs32, {4'b0110, 6'd31}); end
    bus32.abort_h = 1'b1;
    tick();
    bus32.abort_h = 1'b0;
    n_tests++;
    if (obs32 !== 10'b0) begin n_fail++; $display("FAIL reset32_abort: got %b expected %b", obs32, 10'b0); end
  endtask

  task automatic test_load_clear();
    bus4.alkc_load_h = 1'b1; bus4.alu_cout_h = 1'b1;
    tick();
    n_tests++;
    if (obs4 !== {4'b1000, 6'd0}) begin n_fail++; $display("FAIL load_set: got %b expected %b", obs4, {4'b1000, 6'd0}); end
    bus4.alkc_load_h = 1'b0; bus4.alu_cout_h = 1'b0;
    tick();
    n_tests++;
    if (obs4 !== {4'b1000, 6'd0}) begin n_fail++; $display("FAIL load_hold: got %b expected %b", obs4, {4'b1000, 6'd0}); end
    bus4.alkc_clr_h = 1'b1; bus4.alkc_load_h = 1'b1; bus4.alu_cout_h = 1'b1;
    tick();
    n_tests++;
    if (obs4 !== {4'b0000, 6'd0}) begin n_fail++; $display("FAIL clr_over_load: got %b expected %b", obs4, {4'b0000, 6'd0}); end
    bus4.alkc_clr_h = 1'b0;
    tick();
    n_tests++;
    if (obs4 !== {4'b1000, 6'd0}) begin n_fail++; $display("FAIL reload: got %b expected %b", obs4, {4'b1000, 6'd0}); end
    // Abort outranks the IDLE load
    bus4.abort_h = 1'b1; bus4.alu_cout_h = 1'b0;
    tick();
    bus4.abort_h = 1'b0; bus4.alkc_load_h = 1'b0;
    n_tests++;
    if (obs4 !== {4'b1000, 6'd0}) begin n_fail++; $display("FAIL abort_over_load: got %b expected %b", obs4, {4'b1000, 6'd0}); end
  endtask

  task automatic test_div_done();
    logic [3:0] signs;
    logic [9:0] exp_v [6];
    signs = 4'b0010;  // step order 0,1,0,0 (bit i = step i)
    exp_v = '{{4'b1110, 6'd2}, {4'b0010, 6'd1}, {4'b1110, 6'd0}, {4'b1100, 6'd0},
              {4'b1001, 6'd0}, {4'b1000, 6'd0}};
    bus4.div_start_h = 1'b1; bus4.alkc_clr_h = 1'b1;
    tick();
    bus4.div_start_h = 1'b0; bus4.alkc_clr_h = 1'b0;
    n_tests++;
    if (obs4 !== {4'b0110, 6'd3}) begin n_fail++; $display("FAIL done_start: got %b expected %b", obs4, {4'b0110, 6'd3}); end
    for (int i = 0; i < 6; i++) begin
      bus4.alu_sign_h = (i < 4) ? signs[i] : 1'b1;
      tick();
      n_tests++;
      if (obs4 !== exp_v[i]) begin n_fail++; $display("FAIL done_cycle%0d: got %b expected %b", i + 1, obs4, exp_v[i]); end
    end
    bus4.alu_sign_h = 1'b0;
  endtask

  task automatic test_div_fix();
    logic [3:0] signs;
    logic [9:0] exp_v [7];
    signs = 4'b1010;  // step order 0,1,0,1
    exp_v = '{{4'b1110, 6'd2}, {4'b0010, 6'd1}, {4'b1110, 6'd0}, {4'b0010, 6'd0},
              {4'b0000, 6'd0}, {4'b0001, 6'd0}, {4'b0000, 6'd0}};
    bus4.div_start_h = 1'b1; bus4.alkc_load_h = 1'b1; bus4.alu_cout_h = 1'b0;
    tick();
    bus4.div_start_h = 1'b0; bus4.alkc_load_h = 1'b0;
    n_tests++;
    if (obs4 !== {4'b0110, 6'd3}) begin n_fail++; $display("FAIL fix_start: got %b expected %b", obs4, {4'b0110, 6'd3}); end
    for (int i = 0; i < 7; i++) begin
      bus4.alu_sign_h = (i < 4) ? signs[i] : 1'b0;
      tick();
      n_tests++;
      if (obs4 !== exp_v[i]) begin n_fail++; $display("FAIL fix_cycle%0d: got %b expected %b", i + 1, obs4, exp_v[i]); end
    end
  endtask

  task automatic test_stall();
    logic [3:0] signs;
    logic [9:0] exp_v [4];
    bus4.div_start_h = 1'b1;
    tick();
    bus4.div_start_h = 1'b0;
    bus4.alu_sign_h = 1'b0;
    tick();
    n_tests++;
    if (obs4 !== {4'b1110, 6'd2}) begin n_fail++; $display("FAIL stall_pre: got %b expected %b", obs4, {4'b1110, 6'd2}); end
    bus4.ucyc_en_h = 1'b0; bus4.alu_sign_h = 1'b1; bus4.abort_h = 1'b1;
    bus4.alkc_load_h = 1'b1; bus4.alkc_clr_h = 1'b1; bus4.div_start_h = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (obs4 !== {4'b1110, 6'd2}) begin n_fail++; $display("FAIL stall_hold%0d: got %b expected %b", i, obs4, {4'b1110, 6'd2}); end
    end
    bus4.ucyc_en_h = 1'b1; bus4.abort_h = 1'b0;
    bus4.alkc_load_h = 1'b0; bus4.alkc_clr_h = 1'b0; bus4.div_start_h = 1'b0;
    signs = 4'b0001;  // remaining steps 1,0,0 then DONE
    exp_v = '{{4'b0010, 6'd1}, {4'b1110, 6'd0}, {4'b1100, 6'd0}, {4'b1001, 6'd0}};
    for (int i = 0; i < 4; i++) begin
      bus4.alu_sign_h = signs[i];
      tick();
      n_tests++;
      if (obs4 !== exp_v[i]) begin n_fail++; $display("FAIL stall_resume%0d: got %b expected %b", i, obs4, exp_v[i]); end
    end
    bus4.alu_sign_h = 1'b0;
    bus4.ucyc_en_h = 1'b0;
    tick(); tick();
    n_tests++;
    if (obs4 !== {4'b1001, 6'd0}) begin n_fail++; $display("FAIL stall_done_hold: got %b expected %b", obs4, {4'b1001, 6'd0}); end
    bus4.ucyc_en_h = 1'b1;
    tick();
    n_tests++;
    if (obs4 !== {4'b1000, 6'd0}) begin n_fail++; $display("FAIL stall_done_drop: got %b expected %b", obs4, {4'b1000, 6'd0}); end
  endtask

  task automatic test_abort();
    bus4.div_start_h = 1'b1;
    tick();
    n_tests++;
    if (obs4 !== {4'b1110, 6'd3}) begin n_fail++; $display("FAIL abort_start: got %b expected %b", obs4, {4'b1110, 6'd3}); end
    // Start held high while busy must not reload the counter
    bus4.alu_sign_h = 1'b0;
    tick();
    bus4.div_start_h = 1'b0;
    n_tests++;
    if (obs4 !== {4'b1110, 6'd2}) begin n_fail++; $display("FAIL abort_start_ignored: got %b expected %b", obs4, {4'b1110, 6'd2}); end
    tick();
    n_tests++;
    if (obs4 !== {4'b1110, 6'd1}) begin n_fail++; $display("FAIL abort_step2: got %b expected %b", obs4, {4'b1110, 6'd1}); end
    bus4.abort_h = 1'b1; bus4.alu_sign_h = 1'b1;
    tick();
    bus4.abort_h = 1'b0; bus4.alu_sign_h = 1'b0;
    n_tests++;
    if (obs4 !== {4'b1000, 6'd0}) begin n_fail++; $display("FAIL abort_exit: got %b expected %b", obs4, {4'b1000, 6'd0}); end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if (obs4 !== {4'b1000, 6'd0}) begin n_fail++; $display("FAIL abort_quiet%0d: got %b expected %b", i, obs4, {4'b1000, 6'd0}); end
    end
    bus4.abort_h = 1'b1; bus4.div_start_h = 1'b1; bus4.alkc_load_h = 1'b1; bus4.alu_cout_h = 1'b0;
    tick();
    bus4.abort_h = 1'b0; bus4.div_start_h = 1'b0; bus4.alkc_load_h = 1'b0;
    n_tests++;
    if (obs4 !== {4'b1000, 6'd0}) begin n_fail++; $display("FAIL abort_idle: got %b expected %b", obs4, {4'b1000, 6'd0}); end
  endtask

  initial begin
    reset_h = 1'b1;
    idle_inputs();
    test_reset();
    test_load_clear();
    test_div_done();
    test_div_fix();
    test_stall();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
